vram_access_scheduler: RTL and testbench

//  Schedules the single quad-SPI VRAM port between video line reads and Hack CPU word writes.

---
 rtl/vram_access_scheduler.sv | 162 ++++++++++++++++
 tb/tb_vram_access_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_scheduler.sv
// Arbitrates the single quad-SPI VRAM port between deadline-driven video line reads and
// CPU word writes drained from the write FIFO, with per-command timeout supervision.
module vram_access_scheduler #(
    parameter int WORD_WIDTH         = 16,
    parameter int RAM_ADDRESS_WIDTH  = 14,
    parameter int SRAM_ADDRESS_WIDTH = 24,
    parameter int SCREEN_HEIGHT      = 256,
    parameter int READ_TRIGGER       = 42,
    parameter int WRITE_GUARD        = 40,
    parameter int TIMEOUT            = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          init_done,
    input  logic [9:0]                    clks_before_active,
    input  logic [9:0]                    display_vpos,
    input  logic                          fifo_empty,
    input  logic [RAM_ADDRESS_WIDTH-1:0]  fifo_out_address,
    input  logic [WORD_WIDTH-1:0]         fifo_out_data,
    output logic                          fifo_read_request,
    input  logic                          eng_busy,
    input  logic                          eng_done,
    output logic                          eng_start,
    output logic                          eng_op,
    output logic [SRAM_ADDRESS_WIDTH-1:0] eng_addr,
    output logic [WORD_WIDTH-1:0]         eng_wdata,
    output logic [7:0]                    read_miss_count,
    output logic                          eng_timeout
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

    localparam int GUARD_END = READ_TRIGGER + WRITE_GUARD;

    state_t                        state_q, state_d;
    logic                          read_pending_q, read_pending_d;
    logic [9:0]                    vpos_q, vpos_d;
    logic [7:0]                    miss_q, miss_d;
    logic [7:0]                    to_cnt_q, to_cnt_d;
    logic                          timeout_q, timeout_d;
    logic                          start_q, start_d;
    logic                          pop_q, pop_d;
    logic                          op_q, op_d;
    logic [SRAM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]         wdata_q, wdata_d;

    logic [10:0] cba_ext;
    logic [10:0] vpos_ext;
    logic        visible;
    logic        trig;
    logic        in_guard;
    logic        write_ok;
    logic        issue_rd;

    // All comparisons are widened to 11 bits so READ_TRIGGER+WRITE_GUARD cannot wrap.
    assign cba_ext  = {1'b0, clks_before_active};
    assign vpos_ext = {1'b0, display_vpos};
    assign visible  = vpos_ext < 11'(SCREEN_HEIGHT);
    assign trig     = (state_q != S_INIT) && visible && (cba_ext == 11'(READ_TRIGGER));
    assign in_guard = visible && (cba_ext >= 11'(READ_TRIGGER)) && (cba_ext < 11'(GUARD_END));
    assign write_ok = !read_pending_q && !in_guard;

    always_comb begin
        // NOTE: every next-state signal gets its default first so no latch can be inferred.
        state_d        = state_q;
        read_pending_d = read_pending_q;
        vpos_d         = vpos_q;
        miss_d         = miss_q;
        to_cnt_d       = to_cnt_q;
        timeout_d      = timeout_q;
        start_d        = 1'b0;
        pop_d          = 1'b0;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        issue_rd       = 1'b0;

        case (state_q)
            S_INIT: begin
                if (init_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!eng_busy) begin
                    if (read_pending_q) begin
                        state_d        = S_RD;
                        start_d        = 1'b1;
                        op_d           = 1'b0;
                        addr_d         = SRAM_ADDRESS_WIDTH'({vpos_q, 6'b0});
                        read_pending_d = 1'b0;
                        to_cnt_d       = '0;
                        issue_rd       = 1'b1;
                    end else if (!fifo_empty && write_ok) begin
                        state_d  = S_WR;
                        start_d  = 1'b1;
                        pop_d    = 1'b1;
                        op_d     = 1'b1;
                        addr_d   = SRAM_ADDRESS_WIDTH'({fifo_out_address, 1'b0});
                        wdata_d  = fifo_out_data;
                        to_cnt_d = '0;
                    end
                end
            end
            S_RD, S_WR: begin
                if (eng_done) begin
                    state_d = S_IDLE;
                end else if (to_cnt_q == 8'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            default: state_d = S_INIT;
        endcase

        // A newer line overwrites a pending one; only a read already in flight or queued is lost.
        if (trig) begin
            read_pending_d = 1'b1;
            vpos_d         = display_vpos;
            if (((read_pending_q && !issue_rd) || (state_q == S_RD && !eng_done)) &&
                (miss_q != 8'hFF)) begin
                miss_d = miss_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (!reset_n) begin
            state_q        <= S_INIT;
            read_pending_q <= 1'b0;
            vpos_q         <= '0;
            miss_q         <= '0;
            to_cnt_q       <= '0;
            timeout_q      <= 1'b0;
            start_q        <= 1'b0;
            pop_q          <= 1'b0;
            op_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            read_pending_q <= read_pending_d;
            vpos_q         <= vpos_d;
            miss_q         <= miss_d;
            to_cnt_q       <= to_cnt_d;
            timeout_q      <= timeout_d;
            start_q        <= start_d;
            pop_q          <= pop_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
        end
    end

    assign eng_start         = start_q;
    assign fifo_read_request = pop_q;
    assign eng_op            = op_q;
    assign eng_addr          = addr_q;
    assign eng_wdata         = wdata_q;
    assign read_miss_count   = miss_q;
    assign eng_timeout       = timeout_q;
endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler: models the SPI engine, the show-ahead write FIFO
// and a video timing source, and scoreboards every issued command against expected queues.
module tb_vram_access_scheduler;
    typedef struct packed {
        logic        op;
        logic [23:0] addr;
        logic [15:0] data;
    } cmd_t;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
    } fifo_ent_t;

    localparam int RD_CYC = 20;
    localparam int WR_CYC = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_done = 1'b1;
    logic [9:0]  clks_before_active = 10'd200;
    logic [9:0]  display_vpos = 10'd0;
    logic        fifo_empty = 1'b1;
    logic [13:0] fifo_out_address = '0;
    logic [15:0] fifo_out_data = '0;
    logic        fifo_read_request;
    logic        eng_busy = 1'b0;
    logic        eng_done = 1'b0;
    logic        eng_start;
    logic        eng_op;
    logic [23:0] eng_addr;
    logic [15:0] eng_wdata;
    logic [7:0]  read_miss_count;
    logic        eng_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_wr = 0;
    int last_start_cyc = 0;
    int eng_cnt = 0;
    int release_req = 0;
    int release_done = 0;
    logic hold_eng = 1'b0;

    cmd_t      exp_rd_q[$];
    cmd_t      exp_wr_q[$];
    fifo_ent_t fifo_q[$];
    cmd_t      mon_e;

    int t0, base, guard, s_cyc;

    vram_access_scheduler dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .init_done          (init_done),
        .clks_before_active (clks_before_active),
        .display_vpos       (display_vpos),
        .fifo_empty         (fifo_empty),
        .fifo_out_address   (fifo_out_address),
        .fifo_out_data      (fifo_out_data),
        .fifo_read_request  (fifo_read_request),
        .eng_busy           (eng_busy),
        .eng_done           (eng_done),
        .eng_start          (eng_start),
        .eng_op             (eng_op),
        .eng_addr           (eng_addr),
        .eng_wdata          (eng_wdata),
        .read_miss_count    (read_miss_count),
        .eng_timeout        (eng_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_write(input logic [13:0] a, input logic [15:0] d);
        fifo_q.push_back('{addr: a, data: d});
        exp_wr_q.push_back('{op: 1'b1, addr: 24'({a, 1'b0}), data: d});
    endtask

    task automatic push_read(input logic [9:0] v);
        exp_rd_q.push_back('{op: 1'b0, addr: 24'({v, 6'b0}), data: 16'h0});
    endtask

    task automatic wait_start(input string tag, input int target);
        int n = 0;
        while (n_starts < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n_starts >= target), 64'd1);
    endtask

    // Engine model: finishes commands after a fixed latency unless held; a release ends a held one.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (!reset_n) begin
            eng_busy     = 1'b0;
            eng_cnt      = 0;
            release_done = release_req;
        end else if (eng_start) begin
            eng_busy = 1'b1;
            eng_cnt  = eng_op ? WR_CYC : RD_CYC;
        end else if (eng_busy && release_done != release_req) begin
            eng_busy     = 1'b0;
            eng_done     = 1'b1;
            release_done = release_req;
        end else if (eng_busy && !hold_eng) begin
            if (eng_cnt <= 1) begin
                eng_busy = 1'b0;
                eng_done = 1'b1;
            end else begin
                eng_cnt--;
            end
        end
    end

    // Show-ahead FIFO model.
    always @(negedge clk) begin
        if (fifo_read_request && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() > 0) begin
            fifo_out_address = fifo_q[0].addr;
            fifo_out_data    = fifo_q[0].data;
        end
    end

    // Command monitor / scoreboard.
    always @(negedge clk) begin
        if (reset_n && eng_start) begin
            n_starts++;
            last_start_cyc = cyc;
            if (!eng_op) begin
                check("rd_expected", 64'(exp_rd_q.size() > 0), 64'd1);
                if (exp_rd_q.size() > 0) begin
                    mon_e = exp_rd_q.pop_front();
                    check("rd_addr", 64'(eng_addr), 64'(mon_e.addr));
                end
            end else begin
                n_wr++;
                check("wr_expected", 64'(exp_wr_q.size() > 0), 64'd1);
                if (exp_wr_q.size() > 0) begin
                    mon_e = exp_wr_q.pop_front();
                    check("wr_addr", 64'(eng_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(eng_wdata), 64'(mon_e.data));
                end
            end
        end
        if (reset_n && (eng_start || fifo_read_request))
            check("pop_with_write", 64'(fifo_read_request), 64'(eng_start && eng_op));
    end

    initial begin
        // 1. Reset with init_done high: every output low.
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs", 64'({eng_start, eng_op, eng_addr, eng_wdata, fifo_read_request,
                  read_miss_count, eng_timeout}), 64'd0);
        end
        reset_n = 1'b1;

        // 2. Line read: trigger in the first cycle after release proves S_IDLE was reached.
        @(negedge clk);
        display_vpos       = 10'd5;
        clks_before_active = 10'd42;
        push_read(10'd5);
        t0 = cyc;
        @(negedge clk);
        clks_before_active = 10'd200;
        wait_start("rd_start", 1);
        check("rd_latency", 64'(last_start_cyc - t0), 64'd2);
        repeat (3) @(negedge clk);
        check("rd_addr_held", 64'(eng_addr), 64'h140);
        check("rd_op_held", 64'(eng_op), 64'd0);
        repeat (30) @(negedge clk);

        // 3. Single write from the FIFO.
        push_write(14'h0123, 16'hBEEF);
        wait_start("wr_start", 2);
        repeat (3) @(negedge clk);
        check("wr_data_held", 64'(eng_wdata), 64'hBEEF);
        repeat (20) @(negedge clk);

        // 4. Guard boundary: 81 blocks, 82 allows.
        clks_before_active = 10'd81;
        base = n_starts;
        push_write(14'h0ABC, 16'h1234);
        repeat (10) @(negedge clk);
        check("no_write_at_81", 64'(n_starts), 64'(base));
        clks_before_active = 10'd82;
        t0 = cyc;
        wait_start("wr_at_82", base + 1);
        check("wr_82_latency", 64'(last_start_cyc - t0), 64'd1);
        repeat (20) @(negedge clk);

        // 4b. 1000 writes across many lines with real video timing.
        base = n_wr;
        for (int i = 0; i < 1000; i++) push_write(14'($urandom_range(0, 16383)), 16'($urandom));
        display_vpos       = 10'd250;
        clks_before_active = 10'd159;
        guard = 0;
        while (exp_wr_q.size() != 0 && guard < 60000) begin
            @(negedge clk);
            guard++;
            if (clks_before_active == 10'd0) begin
                clks_before_active = 10'd159;
                display_vpos       = (display_vpos == 10'd259) ? 10'd0 : display_vpos + 10'd1;
            end else begin
                clks_before_active = clks_before_active - 10'd1;
            end
            if (clks_before_active == 10'd42 && display_vpos < 10'd256) push_read(display_vpos);
        end
        check("bulk_in_time", 64'(guard < 60000), 64'd1);
        clks_before_active = 10'd200;
        repeat (60) @(negedge clk);
        check("bulk_writes", 64'(n_wr - base), 64'd1000);
        check("bulk_reads_done", 64'(exp_rd_q.size()), 64'd0);
        check("bulk_no_miss", 64'(read_miss_count), 64'd0);

        // 5. Held read across the next trigger -> one miss, then the newer line is read.
        hold_eng           = 1'b1;
        display_vpos       = 10'd10;
        clks_before_active = 10'd42;
        push_read(10'd10);
        @(negedge clk);
        clks_before_active = 10'd200;
        base = n_starts;
        wait_start("held_rd_start", base + 1);
        display_vpos       = 10'd11;
        clks_before_active = 10'd42;
        @(negedge clk);
        clks_before_active = 10'd200;
        @(negedge clk);
        check("miss_one", 64'(read_miss_count), 64'd1);
        push_read(10'd11);
        release_req++;
        wait_start("coalesced_rd_start", base + 2);
        repeat (2) @(negedge clk);
        check("miss_after_reissue", 64'(read_miss_count), 64'd1);

        // 5b. Continuous triggers while reads are held -> saturation.
        display_vpos       = 10'd20;
        clks_before_active = 10'd42;
        repeat (200) @(negedge clk);
        push_read(10'd20);
        release_req++;
        wait_start("sat_rd_start", base + 3);
        repeat (150) @(negedge clk);
        clks_before_active = 10'd200;
        @(negedge clk);
        check("miss_saturated", 64'(read_miss_count), 64'd255);

        // 6. Held read never completes -> timeout 255 cycles after eng_start.
        s_cyc = last_start_cyc;
        guard = 0;
        while (!eng_timeout && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("timeout_set", 64'(eng_timeout), 64'd1);
        check("timeout_latency", 64'(cyc - s_cyc), 64'd255);
        repeat (5) @(negedge clk);
        push_read(10'd20);
        release_req++;
        wait_start("rd_after_timeout", base + 4);
        check("timeout_sticky", 64'(eng_timeout), 64'd1);
        release_req++;
        repeat (5) @(negedge clk);

        // 6b. Reset mid-write with a read pending clears everything.
        display_vpos = 10'd30;
        push_write(14'h3FFF, 16'hA5A5);
        wait_start("wr_before_reset", base + 5);
        clks_before_active = 10'd42;
        @(negedge clk);
        clks_before_active = 10'd200;
        @(negedge clk);
        check("miss_not_on_write", 64'(read_miss_count), 64'd255);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_timeout", 64'(eng_timeout), 64'd0);
        check("mid_rst_miss", 64'(read_miss_count), 64'd0);
        check("mid_rst_outputs", 64'({eng_start, eng_op, eng_addr, eng_wdata,
              fifo_read_request}), 64'd0);
        hold_eng  = 1'b0;
        init_done = 1'b0;
        @(negedge clk);
        reset_n            = 1'b1;
        display_vpos       = 10'd7;
        clks_before_active = 10'd42;
        @(negedge clk);
        clks_before_active = 10'd200;
        base = n_starts;
        repeat (5) @(negedge clk);
        init_done = 1'b1;
        repeat (20) @(negedge clk);
        check("pending_cleared", 64'(n_starts), 64'(base));
        check("no_stray_reads", 64'(exp_rd_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
